// File: rtl/demux_lane_sched.sv
`default_nettype none
// =============================================================================
// Module   : demux_lane_sched
// Purpose  : Round-robin 1-to-2 byte demux scheduler with per-lane credit
//            tracking and valid/ready back-pressure (clk_4f domain).
// Revision : 1.0 - initial release
// =============================================================================
module demux_lane_sched #(
    parameter int DATA_W   = 8,
    parameter int CREDITS  = 4,
    parameter int CNT_W    = 3,
    parameter int INIT_CYC = 2
) (
    input  logic              clk_4f,
    input  logic              reset,
    input  logic [DATA_W-1:0] Entrada,
    input  logic              validEntrada,
    output logic              ready,
    input  logic              pop0,
    input  logic              pop1,
    output logic [DATA_W-1:0] Salida_conductual0,
    output logic [DATA_W-1:0] Salida_conductual1,
    output logic              validsalida0,
    output logic              validsalida1,
    output logic              sel,
    output logic              stall,
    output logic              err
);

    localparam int                INIT_W    = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
    localparam logic [CNT_W-1:0]  CRED_MAX  = CNT_W'(CREDITS);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYC - 1);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_STALL  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [INIT_W-1:0]   init_cnt_q;
    logic [CNT_W-1:0]    cred0_q, cred0_d;
    logic [CNT_W-1:0]    cred1_q, cred1_d;
    logic                sel_q, sel_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   data0_q, data1_q;
    logic                valid0_q, valid1_q;

    logic                w_ready;
    logic                w_accept;
    logic                w_dec0, w_dec1;
    logic                w_ovf0, w_ovf1;
    logic [CNT_W-1:0]    w_cred_sel_q;
    logic [CNT_W-1:0]    w_cred_sel_d;

    always_comb begin
        w_cred_sel_q = sel_q ? cred1_q : cred0_q;
        w_ready      = (state_q == ST_ACTIVE) && (w_cred_sel_q != '0);
        w_accept     = validEntrada && w_ready;
        w_dec0       = w_accept && !sel_q;
        w_dec1       = w_accept &&  sel_q;

        // A pop against a full counter is a downstream protocol error: the
        // count saturates instead of wrapping past the FIFO depth.
        w_ovf0  = pop0 && !w_dec0 && (cred0_q == CRED_MAX);
        w_ovf1  = pop1 && !w_dec1 && (cred1_q == CRED_MAX);
        cred0_d = w_ovf0 ? cred0_q : (cred0_q - CNT_W'(w_dec0) + CNT_W'(pop0));
        cred1_d = w_ovf1 ? cred1_q : (cred1_q - CNT_W'(w_dec1) + CNT_W'(pop1));

        sel_d        = sel_q ^ w_accept;
        err_d        = err_q | w_ovf0 | w_ovf1;
        w_cred_sel_d = sel_d ? cred1_d : cred0_d;

        // Stall decision uses next-cycle lane/credit so a same-cycle pop keeps
        // the block ACTIVE and a returning credit exits STALL immediately.
        state_d = state_q;
        case (state_q)
            ST_INIT:   state_d = (init_cnt_q == INIT_LAST) ? ST_ACTIVE : ST_INIT;
            ST_ACTIVE: state_d = (w_cred_sel_d == '0) ? ST_STALL : ST_ACTIVE;
            ST_STALL:  state_d = (w_cred_sel_d == '0) ? ST_STALL : ST_ACTIVE;
            default:   state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            cred0_q    <= CRED_MAX;
            cred1_q    <= CRED_MAX;
            sel_q      <= 1'b0;
            err_q      <= 1'b0;
            data0_q    <= '0;
            data1_q    <= '0;
            valid0_q   <= 1'b0;
            valid1_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cred0_q <= cred0_d;
            cred1_q <= cred1_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
            if (state_q == ST_INIT) begin
                init_cnt_q <= init_cnt_q + 1'b1;
            end
            valid0_q <= w_dec0;
            valid1_q <= w_dec1;
            if (w_dec0) begin
                data0_q <= Entrada;
            end
            if (w_dec1) begin
                data1_q <= Entrada;
            end
        end
    end

    assign ready              = w_ready;
    assign sel                = sel_q;
    assign stall              = (state_q == ST_STALL);
    assign err                = err_q;
    assign Salida_conductual0 = data0_q;
    assign Salida_conductual1 = data1_q;
    assign validsalida0       = valid0_q;
    assign validsalida1       = valid1_q;

endmodule
`default_nettype wire

// File: tb/tb_demux_lane_sched.sv
`default_nettype none
// =============================================================================
// Module   : tb_demux_lane_sched
// Purpose  : Directed self-checking bench for demux_lane_sched.
// Revision : 1.0 - initial release
// =============================================================================
module tb_demux_lane_sched;

    logic       clk_4f = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] Entrada = 8'h00;
    logic       validEntrada = 1'b0;
    logic       pop0 = 1'b0;
    logic       pop1 = 1'b0;
    logic       ready;
    logic [7:0] Salida_conductual0, Salida_conductual1;
    logic       validsalida0, validsalida1, sel, stall, err;

    int total = 0;
    int bad   = 0;

    demux_lane_sched #(.DATA_W(8), .CREDITS(4), .CNT_W(3), .INIT_CYC(2)) dut (
        .clk_4f(clk_4f), .reset(reset), .Entrada(Entrada), .validEntrada(validEntrada),
        .ready(ready), .pop0(pop0), .pop1(pop1),
        .Salida_conductual0(Salida_conductual0), .Salida_conductual1(Salida_conductual1),
        .validsalida0(validsalida0), .validsalida1(validsalida1),
        .sel(sel), .stall(stall), .err(err)
    );

    always #5 clk_4f = ~clk_4f;

    task automatic step();
        @(posedge clk_4f);
        #1;
    endtask

    task automatic do_reset();
        validEntrada = 1'b0; pop0 = 1'b0; pop1 = 1'b0; Entrada = 8'h00;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        total++;
        if ({Salida_conductual0, Salida_conductual1, validsalida0, validsalida1, sel, ready, stall, err} !== 22'h0) begin
            bad++;
            $display("FAIL reset_outputs: got d0=%h d1=%h v0=%b v1=%b sel=%b rdy=%b stall=%b err=%b expected all 0",
                     Salida_conductual0, Salida_conductual1, validsalida0, validsalida1, sel, ready, stall, err);
        end
        reset = 1'b0;
        step();
        total++;
        if (ready !== 1'b0) begin bad++; $display("FAIL init_ready_c1: got %b expected 0", ready); end
        step();
        total++;
        if (ready !== 1'b1) begin bad++; $display("FAIL init_ready_c2: got %b expected 1", ready); end
        total++;
        if (stall !== 1'b0 || err !== 1'b0) begin
            bad++; $display("FAIL init_flags: got stall=%b err=%b expected 0 0", stall, err);
        end
    endtask

    task automatic test_stripe();
        logic [7:0] bytes [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        logic [7:0] exp0, exp1;
        do_reset();
        exp0 = 8'h00; exp1 = 8'h00;
        pop0 = 1'b1; pop1 = 1'b1; validEntrada = 1'b1;
        for (int i = 0; i < 4; i++) begin
            Entrada = bytes[i];
            total++;
            if (sel !== i[0]) begin bad++; $display("FAIL stripe_sel[%0d]: got %b expected %b", i, sel, i[0]); end
            step();
            if (i[0]) exp1 = bytes[i]; else exp0 = bytes[i];
            total++;
            if (Salida_conductual0 !== exp0 || Salida_conductual1 !== exp1 ||
                validsalida0 !== !i[0] || validsalida1 !== i[0]) begin
                bad++;
                $display("FAIL stripe_out[%0d]: got d0=%h d1=%h v0=%b v1=%b expected d0=%h d1=%h v0=%b v1=%b",
                         i, Salida_conductual0, Salida_conductual1, validsalida0, validsalida1,
                         exp0, exp1, !i[0], i[0]);
            end
        end
        validEntrada = 1'b0; pop0 = 1'b0; pop1 = 1'b0;
        step();
        total++;
        if (validsalida0 !== 1'b0 || validsalida1 !== 1'b0 || Salida_conductual0 !== 8'hC3 || Salida_conductual1 !== 8'hD4) begin
            bad++;
            $display("FAIL stripe_idle: got v0=%b v1=%b d0=%h d1=%h expected 0 0 c3 d4",
                     validsalida0, validsalida1, Salida_conductual0, Salida_conductual1);
        end
        // The first cycle popped lane 1 while it was full.
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL stripe_err: got %b expected 1", err); end
    endtask

    task automatic test_credit_stall();
        do_reset();
        validEntrada = 1'b1;
        for (int i = 0; i < 8; i++) begin
            Entrada = 8'h10 + 8'(i);
            total++;
            if (ready !== 1'b1) begin bad++; $display("FAIL credit_ready[%0d]: got %b expected 1", i, ready); end
            step();
        end
        total++;
        if (ready !== 1'b0 || stall !== 1'b1 || sel !== 1'b0) begin
            bad++; $display("FAIL credit_stall: got rdy=%b stall=%b sel=%b expected 0 1 0", ready, stall, sel);
        end
        total++;
        if (Salida_conductual0 !== 8'h16 || Salida_conductual1 !== 8'h17 || validsalida1 !== 1'b1) begin
            bad++; $display("FAIL credit_last: got d0=%h d1=%h v1=%b expected 16 17 1",
                            Salida_conductual0, Salida_conductual1, validsalida1);
        end
        Entrada = 8'h99;
        repeat (2) step();
        total++;
        if (ready !== 1'b0 || stall !== 1'b1 || validsalida0 !== 1'b0 || validsalida1 !== 1'b0 || Salida_conductual0 !== 8'h16) begin
            bad++; $display("FAIL credit_hold: got rdy=%b stall=%b v0=%b v1=%b d0=%h expected 0 1 0 0 16",
                            ready, stall, validsalida0, validsalida1, Salida_conductual0);
        end
    endtask

    task automatic test_stall_exit();
        pop1 = 1'b1;
        step();
        pop1 = 1'b0;
        total++;
        if (stall !== 1'b1 || ready !== 1'b0) begin
            bad++; $display("FAIL exit_pop1: got stall=%b rdy=%b expected 1 0", stall, ready);
        end
        pop0 = 1'b1;
        step();
        pop0 = 1'b0;
        total++;
        if (stall !== 1'b0 || ready !== 1'b1 || sel !== 1'b0) begin
            bad++; $display("FAIL exit_pop0: got stall=%b rdy=%b sel=%b expected 0 1 0", stall, ready, sel);
        end
        step();
        validEntrada = 1'b0;
        total++;
        if (Salida_conductual0 !== 8'h99 || validsalida0 !== 1'b1 || validsalida1 !== 1'b0 || sel !== 1'b1) begin
            bad++; $display("FAIL exit_byte9: got d0=%h v0=%b v1=%b sel=%b expected 99 1 0 1",
                            Salida_conductual0, validsalida0, validsalida1, sel);
        end
        total++;
        if (stall !== 1'b0 || ready !== 1'b1) begin
            bad++; $display("FAIL exit_lane1: got stall=%b rdy=%b expected 0 1", stall, ready);
        end
    endtask

    task automatic test_err_sticky();
        do_reset();
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL err_clear: got %b expected 0", err); end
        pop0 = 1'b1;
        step();
        pop0 = 1'b0;
        repeat (3) step();
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b expected 1", err); end
        // Saturated lane 0 still holds exactly 4 credits: 8 accepts must stall.
        validEntrada = 1'b1;
        for (int i = 0; i < 8; i++) begin
            Entrada = 8'h20 + 8'(i);
            step();
        end
        validEntrada = 1'b0;
        total++;
        if (stall !== 1'b1 || err !== 1'b1) begin
            bad++; $display("FAIL err_saturate: got stall=%b err=%b expected 1 1", stall, err);
        end
        do_reset();
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL err_reset: got %b expected 0", err); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        validEntrada = 1'b1;
        for (int i = 0; i < 6; i++) begin
            Entrada = 8'h30 + 8'(i);
            step();
        end
        // cred0 = 1, cred1 = 1, sel = 0: accept on lane 0 with a pop on lane 0.
        Entrada = 8'h3A; pop0 = 1'b1;
        step();
        pop0 = 1'b0;
        total++;
        if (stall !== 1'b0 || ready !== 1'b1 || sel !== 1'b1 || Salida_conductual0 !== 8'h3A) begin
            bad++; $display("FAIL same_accept_pop: got stall=%b rdy=%b sel=%b d0=%h expected 0 1 1 3a",
                            stall, ready, sel, Salida_conductual0);
        end
        Entrada = 8'h3B;
        step();
        total++;
        if (stall !== 1'b0 || ready !== 1'b1 || sel !== 1'b0) begin
            bad++; $display("FAIL same_cred0_kept: got stall=%b rdy=%b sel=%b expected 0 1 0", stall, ready, sel);
        end
        Entrada = 8'h3C;
        step();
        validEntrada = 1'b0;
        total++;
        if (stall !== 1'b1 || ready !== 1'b0 || Salida_conductual0 !== 8'h3C) begin
            bad++; $display("FAIL same_drain: got stall=%b rdy=%b d0=%h expected 1 0 3c", stall, ready, Salida_conductual0);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        validEntrada = 1'b1; Entrada = 8'h55;
        step();
        Entrada = 8'h66; reset = 1'b1;
        step();
        total++;
        if (validsalida0 !== 1'b0 || validsalida1 !== 1'b0 || Salida_conductual0 !== 8'h00 ||
            Salida_conductual1 !== 8'h00 || sel !== 1'b0 || ready !== 1'b0) begin
            bad++; $display("FAIL mid_reset: got v0=%b v1=%b d0=%h d1=%h sel=%b rdy=%b expected all 0",
                            validsalida0, validsalida1, Salida_conductual0, Salida_conductual1, sel, ready);
        end
        reset = 1'b0; validEntrada = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stripe();
        test_credit_stall();
        test_stall_exit();
        test_err_sticky();
        test_same_cycle();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
